// File: rtl/regwb_arbiter.sv
// ============================================================================
// regwb_arbiter
//
// Purpose:
//   Arbitrates the register-file write port between two writeback sources:
//   the ALU (side A) and the load unit (side B). A request transfers in any
//   cycle where valid and ready are both high. An accepted write reaches the
//   register file through a registered port one cycle later.
//
//   Writes whose destination has addr[5]=1 fall outside the register file.
//   They are still accepted (ready high) so the requester is not stalled,
//   but they are discarded and counted in drop_count.
//
//   Cycles in which both sides request at once are counted in conflict_count.
//   Both counters saturate at 2^CNT_W-1 and never wrap.
//
// Configuration:
//   REGWB_RR_ARB_EN  defined   : round-robin. On a conflict, the side that
//                                did not win the last granted transfer wins
//                                this time.
//                    undefined : fixed priority (default). A always wins a
//                                conflict. last_grant is still tracked.
//
// Parameters:
//   CNT_W           width of conflict_count and drop_count (default 8)
//
// Ports:
//   clk             clock, rising edge
//   reset           synchronous, active-high reset
//   a_valid/a_ready ALU writeback handshake (ready is combinational)
//   a_addr/a_data   ALU destination register (6 bits) and result (32 bits)
//   b_valid/b_ready load-unit writeback handshake (ready is combinational)
//   b_addr/b_data   load-unit destination register and load data
//   wr_en           registered register-file write enable
//   wr_addr         registered register-file write address
//   wr_data         registered register-file write data
//   conflict_count  saturating count of cycles with both requests valid
//   drop_count      saturating count of accepted out-of-range writes
// ============================================================================
module regwb_arbiter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             a_valid,
    output logic             a_ready,
    input  logic [5:0]       a_addr,
    input  logic [31:0]      a_data,

    input  logic             b_valid,
    output logic             b_ready,
    input  logic [5:0]       b_addr,
    input  logic [31:0]      b_data,

    output logic             wr_en,
    output logic [5:0]       wr_addr,
    output logic [31:0]      wr_data,

    output logic [CNT_W-1:0] conflict_count,
    output logic [CNT_W-1:0] drop_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Priority state: side of the most recent granted transfer (0=A, 1=B).
    logic        last_grant;

    // High when A wins a simultaneous request.
    logic        a_wins;

    // Selected transfer for this cycle.
    logic        xfer;
    logic [5:0]  sel_addr;
    logic [31:0] sel_data;
    logic        sel_in_range;
    logic        conflict;

`ifdef REGWB_RR_ARB_EN
    // B won last time (last_grant=1) -> A's turn, and vice versa.
    assign a_wins = last_grant;
`else
    // Fixed priority: A always wins. last_grant is kept for observability,
    // and is folded in here only so that it stays referenced.
    assign a_wins = last_grant | 1'b1;
`endif

    // Ready is purely combinational from the requests and priority state.
    // The two readies are mutually exclusive by construction, and both are
    // held low during reset so nothing transfers.
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (!reset) begin
            a_ready = a_valid && (!b_valid || a_wins);
            b_ready = b_valid && (!a_valid || !a_wins);
        end
    end

    always_comb begin
        xfer         = a_ready || b_ready;
        sel_addr     = a_ready ? a_addr : b_addr;
        sel_data     = a_ready ? a_data : b_data;
        sel_in_range = !sel_addr[5];
        conflict     = a_valid && b_valid;
    end

    // Registered write port and priority bit. wr_addr/wr_data only load on
    // a write-producing transfer, so they hold across idle and dropped cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en      <= 1'b0;
            wr_addr    <= 6'd0;
            wr_data    <= 32'd0;
            last_grant <= 1'b1;
        end else begin
            wr_en <= xfer && sel_in_range;
            if (xfer && sel_in_range) begin
                wr_addr <= sel_addr;
                wr_data <= sel_data;
            end
            if (xfer) begin
                last_grant <= b_ready;
            end
        end
    end

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            conflict_count <= '0;
            drop_count     <= '0;
        end else begin
            if (conflict && (conflict_count != CNT_MAX)) begin
                conflict_count <= conflict_count + 1'b1;
            end
            if (xfer && !sel_in_range && (drop_count != CNT_MAX)) begin
                drop_count <= drop_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regwb_arbiter.sv
// ============================================================================
// tb_regwb_arbiter
//
// Directed testbench for regwb_arbiter. Each stimulus step drives one cycle
// of inputs, checks the combinational readies against hand-computed values
// and pushes the expected register-file write (if any) into a queue. An
// independent monitor pops that queue whenever wr_en is seen high. Expected
// grant orders depend on whether REGWB_RR_ARB_EN is defined.
// ============================================================================
module tb_regwb_arbiter;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             a_valid = 1'b0;
    logic             a_ready;
    logic [5:0]       a_addr = 6'd0;
    logic [31:0]      a_data = 32'd0;
    logic             b_valid = 1'b0;
    logic             b_ready;
    logic [5:0]       b_addr = 6'd0;
    logic [31:0]      b_data = 32'd0;
    logic             wr_en;
    logic [5:0]       wr_addr;
    logic [31:0]      wr_data;
    logic [CNT_W-1:0] conflict_count;
    logic [CNT_W-1:0] drop_count;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [5:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];

    regwb_arbiter #(.CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .a_valid        (a_valid),
        .a_ready        (a_ready),
        .a_addr         (a_addr),
        .a_data         (a_data),
        .b_valid        (b_valid),
        .b_ready        (b_ready),
        .b_addr         (b_addr),
        .b_data         (b_data),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .conflict_count (conflict_count),
        .drop_count     (drop_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    // Drives one cycle starting at a falling edge, checks readies, queues the
    // expected write, then returns at the next falling edge so the registered
    // outputs of that cycle can be inspected.
    task automatic applyStimulus(input logic rst,
                                 input logic av, input logic [5:0] aa, input logic [31:0] ad,
                                 input logic bv, input logic [5:0] ba, input logic [31:0] bd,
                                 input logic exp_ar, input logic exp_br);
        reset   = rst;
        a_valid = av;
        a_addr  = aa;
        a_data  = ad;
        b_valid = bv;
        b_addr  = ba;
        b_data  = bd;
        #1;
        checkOutput("a_ready", 32'(a_ready), 32'(exp_ar));
        checkOutput("b_ready", 32'(b_ready), 32'(exp_br));
        if (exp_ar && !aa[5]) exp_q.push_back(wr_t'{addr: aa, data: ad});
        if (exp_br && !ba[5]) exp_q.push_back(wr_t'{addr: ba, data: bd});
        @(negedge clk);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0, 1'b0, 1'b0);
    endtask

    // Reset with both sides requesting: nothing may be granted.
    task automatic resetDut();
        applyStimulus(1'b1, 1'b1, 6'd9, 32'h99, 1'b1, 6'd10, 32'h1010, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 6'd9, 32'h99, 1'b1, 6'd10, 32'h1010, 1'b0, 1'b0);
    endtask

    // Scoreboard monitor: every observed write must match the queue head.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_write", 32'(wr_addr), 32'h3f);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                checkOutput("wr_addr", 32'(wr_addr), 32'(e.addr));
                checkOutput("wr_data", wr_data, e.data);
            end
        end
    end

    initial begin
        logic exp_a;
        @(negedge clk);

        // Reset state
        resetDut();
        checkOutput("rst_wr_en", 32'(wr_en), 32'd0);
        checkOutput("rst_wr_addr", 32'(wr_addr), 32'd0);
        checkOutput("rst_wr_data", wr_data, 32'd0);
        checkOutput("rst_conflict", 32'(conflict_count), 32'd0);
        checkOutput("rst_drop", 32'(drop_count), 32'd0);

        // Single ALU write in the first cycle after reset
        applyStimulus(1'b0, 1'b1, 6'd3, 32'h11, 1'b0, 6'd0, 32'd0, 1'b1, 1'b0);
        checkOutput("single_wr_en", 32'(wr_en), 32'd1);
        idleCycle();
        checkOutput("idle_wr_en", 32'(wr_en), 32'd0);
        checkOutput("idle_hold_addr", 32'(wr_addr), 32'd3);
        checkOutput("idle_hold_data", wr_data, 32'h11);

        // Sustained conflict for 4 cycles
        resetDut();
        for (int i = 0; i < 4; i++) begin
`ifdef REGWB_RR_ARB_EN
            exp_a = (i % 2 == 0);
`else
            exp_a = 1'b1;
`endif
            applyStimulus(1'b0, 1'b1, 6'd1, 32'hA1, 1'b1, 6'd2, 32'hB2, exp_a, !exp_a);
            checkOutput("conflict_wr_en", 32'(wr_en), 32'd1);
        end
        idleCycle();
        checkOutput("conflict_count4", 32'(conflict_count), 32'd4);
        checkOutput("conflict_drop0", 32'(drop_count), 32'd0);

        // Same address from both sides: serialized, B's data lands last
        resetDut();
        applyStimulus(1'b0, 1'b1, 6'd5, 32'hAA, 1'b1, 6'd5, 32'hBB, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 6'd5, 32'hBB, 1'b0, 1'b1);
        checkOutput("same_addr_final_en", 32'(wr_en), 32'd1);
        idleCycle();
        checkOutput("same_addr_final_addr", 32'(wr_addr), 32'd5);
        checkOutput("same_addr_final_data", wr_data, 32'hBB);

        // Out-of-range load writes: accepted, dropped, counter saturates
        resetDut();
        applyStimulus(1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 6'h21, 32'h5, 1'b0, 1'b1);
        checkOutput("drop_wr_en", 32'(wr_en), 32'd0);
        checkOutput("drop_count1", 32'(drop_count), 32'd1);
        for (int i = 1; i < 300; i++) begin
            applyStimulus(1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 6'h21, 32'(i), 1'b0, 1'b1);
        end
        checkOutput("drop_count_sat", 32'(drop_count), 32'd255);
        checkOutput("drop_sat_wr_en", 32'(wr_en), 32'd0);

        // Conflict counter saturation with both sides out of range
        resetDut();
        for (int i = 0; i < 300; i++) begin
`ifdef REGWB_RR_ARB_EN
            exp_a = (i % 2 == 0);
`else
            exp_a = 1'b1;
`endif
            applyStimulus(1'b0, 1'b1, 6'h20, 32'd1, 1'b1, 6'h21, 32'd2, exp_a, !exp_a);
        end
        idleCycle();
        checkOutput("conflict_count_sat", 32'(conflict_count), 32'd255);
        checkOutput("conflict_drop_sat", 32'(drop_count), 32'd255);

        // Reset right after a transfer
        resetDut();
        applyStimulus(1'b0, 1'b1, 6'd7, 32'h77, 1'b0, 6'd0, 32'd0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 6'd7, 32'h77, 1'b1, 6'd8, 32'h88, 1'b0, 1'b0);
        checkOutput("rst_after_xfer_wr_en", 32'(wr_en), 32'd0);
        checkOutput("rst_after_xfer_conflict", 32'(conflict_count), 32'd0);
        checkOutput("rst_after_xfer_drop", 32'(drop_count), 32'd0);
        idleCycle();
        idleCycle();

        checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regwb_arbiter.md
REGWB_ARBITER -- requirements
Module: regwb_arbiter

Interface
REQ-001 Parameter CNT_W, default 8, SHALL set the width of the conflict and drop counters.
REQ-002 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 a_valid  input  1  ALU writeback request.
REQ-005 a_ready  output  1  ALU request granted this cycle.
REQ-006 a_addr  input  6  ALU destination register.
REQ-007 a_data  input  32  ALU result.
REQ-008 b_valid  input  1  load-unit writeback request.
REQ-009 b_ready  output  1  load-unit request granted this cycle.
REQ-010 b_addr  input  6  load-unit destination register.
REQ-011 b_data  input  32  load data.
REQ-012 wr_en  output  1  register-file write enable, registered.
REQ-013 wr_addr  output  6  register-file write address, registered.
REQ-014 wr_data  output  32  register-file write data, registered.
REQ-015 conflict_count  output  CNT_W  cycles with a_valid and b_valid both high, saturating.
REQ-016 drop_count  output  CNT_W  accepted writes discarded for out-of-range address, saturating.

Function
REQ-017 A request SHALL transfer in a cycle where valid and ready are both high; requesters SHALL hold addr/data stable while valid is high and ready is low.
REQ-018 Ready SHALL be combinational from valid and the priority state; at most one of a_ready/b_ready SHALL be high per cycle.
REQ-019 Exactly one valid requester SHALL be granted in the same cycle; with neither valid, both readies SHALL be low.
REQ-020 With both valid, the granted side SHALL be chosen per REQ-032/REQ-033; the loser SHALL see ready low and retry the next cycle.
REQ-021 The arbiter SHALL hold one priority bit, last_grant (0=A, 1=B), updated only on a granted transfer.
REQ-022 A transfer with addr[5]=0 SHALL produce wr_en=1 with the transferred addr/data exactly one cycle later (latency 1).
REQ-023 A transfer with addr[5]=1 SHALL be accepted (ready high), SHALL leave wr_en low the next cycle, and SHALL increment drop_count.
REQ-024 In any cycle without a write-producing transfer, wr_en SHALL be 0 the next cycle; wr_addr/wr_data SHALL hold their previous values.
REQ-025 Back-to-back transfers SHALL yield wr_en high on consecutive cycles, one write per cycle, no bubble.
REQ-026 Both valid with equal addresses SHALL be serialized in grant order, so the later grant's data is the final register value.
REQ-027 conflict_count and drop_count SHALL saturate at 2^CNT_W-1 and never wrap.

Reset
REQ-028 With reset high at a rising edge: wr_en=0, wr_addr=0, wr_data=0, last_grant=1 (A wins the first conflict), both counters=0.
REQ-029 While reset is high, a_ready and b_ready SHALL be 0 and no transfer SHALL occur.
REQ-030 Reset asserted the cycle after a transfer SHALL cancel its pending write (wr_en=0 after the reset edge).
REQ-031 The first cycle after reset deasserts SHALL arbitrate normally.

Configuration
REQ-032 With macro REGWB_RR_ARB_EN defined: round-robin; on conflict the side not equal to last_grant SHALL win, alternating A,B,A,B under sustained conflict.
REQ-033 Without REGWB_RR_ARB_EN: fixed priority; A SHALL always win a conflict; last_grant SHALL still be tracked but unused.

Verification
REQ-034 Reset, then a_valid=1 a_addr=3 a_data=0x11 for one cycle -> a_ready=1 same cycle; next cycle wr_en=1 wr_addr=3 wr_data=0x11; following cycle wr_en=0.
REQ-035 Both valid for 4 cycles (a_addr=1, b_addr=2), RR build -> grants A,B,A,B; conflict_count=4; writes appear one cycle behind each grant.
REQ-036 Same stimulus as REQ-035, non-RR build -> grants A,A,A,A; b_ready stays 0; conflict_count=4.
REQ-037 b_valid=1 b_addr=0x21 -> b_ready=1, wr_en stays 0 next cycle, drop_count=1; 300 such transfers with CNT_W=8 -> drop_count=255.
REQ-038 a_valid and b_valid both with addr=5 (A=0xAA, B=0xBB), RR build after reset -> wr_data 0xAA then 0xBB on consecutive cycles at wr_addr=5.
REQ-039 Transfer a_addr=7 then reset high the next cycle -> wr_en=0 after the reset edge, counters 0, readies 0 during reset.
